// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low key matrix one row at a time. Each row is driven for
// SCAN_TICKS+1 clock cycles and the columns are sampled on the last cycle of
// that dwell. A key is accepted after DEBOUNCE_SCANS consecutive samples agree,
// and released after DEBOUNCE_SCANS consecutive all-high samples.
//
// key_valid is a one-cycle event strobe with no back-pressure: the consumer
// must take key_code on any cycle where key_valid is high, and key_code stays
// stable until the next acceptance.
//
// Optional feature: define KEYPAD_REPEAT_EN to add auto-repeat. A key held for
// REPEAT_SCANS samples then produces another key_valid pulse with the same
// key_code. Without the macro no repeat counter exists.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   row[3:0]    out  row drive, active-low, at most one bit low
//   col[3:0]    in   column sense, active-low, already synchronised to clk
//   key_code    out  accepted key {row_index, col_index}
//   key_valid   out  one-cycle pulse per accepted press (or repeat)
//   key_held    out  high from press acceptance until release acceptance
//   dbg_state_o out  current FSM state (0 SCAN, 1 DEBOUNCE, 2 HELD, 3 RELEASE)
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_TICKS     = 1200,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] dbg_state_o
);

  localparam int TW = (SCAN_TICKS > 0) ? $clog2(SCAN_TICKS + 1) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_TICKS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  logic          sample;
  logic          any_low;
  logic [1:0]    low_idx;
  logic [CW-1:0] cnt_inc;
  logic          accept;
  logic          let_go;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS);
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  assign rep_inc = rep_q + RW'(1);
`endif

  // Lowest-index low column wins when several keys share the driven row.
  function automatic logic [1:0] lowest_low(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign sample  = (timer_q == TIMER_LAST);
  assign any_low = (col != 4'hF);
  assign low_idx = lowest_low(col);
  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    timer_d     = sample ? '0 : timer_q + TW'(1);
    row_idx_d   = row_idx_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
    let_go      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif

    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (!any_low) begin
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            cand_d = {row_idx_q, low_idx};
            cnt_d  = CNT_ONE;
            // A one-sample debounce accepts straight from SCAN.
            if (CNT_ONE == CNT_LAST) accept = 1'b1;
            else                     state_d = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (any_low && (low_idx == cand_q[1:0])) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) accept = 1'b1;
          end else begin
            state_d   = ST_SCAN;
            row_idx_d = row_idx_q + 2'd1;
            cnt_d     = '0;
          end
        end
        ST_HELD: begin
          if (!any_low) begin
            if (CNT_ONE == CNT_LAST) begin
              let_go = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = CNT_ONE;
            end
`ifdef KEYPAD_REPEAT_EN
            rep_d = '0;
          end else if (!col[cand_q[1:0]]) begin
            if (rep_inc == REP_LAST) begin
              rep_d       = '0;
              key_valid_d = !key_valid_q;
            end else begin
              rep_d = rep_inc;
            end
`else
            // No auto-repeat: a held key stays silent until it is released.
`endif
          end
        end
        ST_RELEASE: begin
          if (!any_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) let_go = 1'b1;
          end else begin
            // Bounce during release: back to HELD, no new event.
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end

    if (accept) begin
      key_code_d  = cand_d;
      // Gating on the current pulse keeps key_valid from ever lasting 2 cycles.
      key_valid_d = !key_valid_q;
      key_held_d  = 1'b1;
      state_d     = ST_HELD;
      cnt_d       = '0;
`ifdef KEYPAD_REPEAT_EN
      rep_d       = '0;
`endif
    end

    if (let_go) begin
      key_held_d = 1'b0;
      state_d    = ST_SCAN;
      row_idx_d  = row_idx_q + 2'd1;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      timer_q     <= '0;
      row_idx_q   <= 2'd0;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      row_idx_q   <= row_idx_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign row         = ~(4'b0001 << row_idx_q);
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Bench for keypad_scanner with SCAN_TICKS=3, DEBOUNCE_SCANS=3, REPEAT_SCANS=4.
// A keypad model turns a per-row pressed-column pattern into col. A reference
// model, stepped once per clock, predicts row/key_code/key_valid/key_held every
// cycle. Directed vectors and hand sequences cover the corner cases; random
// press/bounce/reset activity is checked by the model.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int ST = 3;
  localparam int DB = 3;
  localparam int RS = 4;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  // Keypad: pressed columns per row; only the driven (low) row reaches col.
  logic [3:0] press_pat [4];
  assign col = (row[0] ? 4'hF : press_pat[0]) & (row[1] ? 4'hF : press_pat[1]) &
               (row[2] ? 4'hF : press_pat[2]) & (row[3] ? 4'hF : press_pat[3]);

  keypad_scanner #(
    .SCAN_TICKS    (ST),
    .DEBOUNCE_SCANS(DB),
    .REPEAT_SCANS  (RS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row        (row),
    .col        (col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vld_cnt = 0;
  int base  = 0;
  bit prev_valid = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 looking for a press, 1 confirming, 2 key down, 3 confirming release
  int m_age, m_row, m_phase, m_key, m_streak, m_rep, m_code;
  bit m_valid, m_held, m_smp;

  function automatic int lowest(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (!c[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] row_pat(input int r);
    logic [3:0] v;
    v = 4'hF;
    v[r] = 1'b0;
    return v;
  endfunction

  task automatic model_edge(input logic rst, input logic [3:0] c);
    int lc;
    m_valid = 1'b0;
    m_smp   = 1'b0;
    if (rst !== 1'b1) begin
      m_age = 0; m_row = 0; m_phase = 0; m_key = 0; m_streak = 0;
      m_rep = 0; m_code = 0; m_held = 1'b0;
      return;
    end
    m_smp = ((m_age % (ST + 1)) == ST);
    m_age++;
    if (!m_smp) return;
    lc = lowest(c);
    case (m_phase)
      0: if (lc < 0) m_row = (m_row + 1) % 4;
         else begin m_key = m_row * 4 + lc; m_streak = 1; m_phase = 1; end
      1: if (lc == m_key % 4) m_streak++;
         else begin m_phase = 0; m_row = (m_row + 1) % 4; end
      2: if (lc < 0) begin m_phase = 3; m_streak = 1; m_rep = 0; end
         else if (REP_ON && !c[m_key % 4]) begin
           m_rep++;
           if (m_rep == RS) begin m_rep = 0; m_valid = 1'b1; end
         end
      3: if (lc < 0) m_streak++;
         else m_phase = 2;
      default: ;
    endcase
    if (m_phase == 1 && m_streak >= DB) begin
      m_phase = 2; m_code = m_key; m_valid = 1'b1; m_held = 1'b1; m_rep = 0;
    end
    if (m_phase == 3 && m_streak >= DB) begin
      m_phase = 0; m_held = 1'b0; m_row = (m_row + 1) % 4;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: predict, advance, then compare every output against the model.
  task automatic tick();
    model_edge(rst_n, press_pat[m_row]);
    @(posedge clk);
    #1;
    cyc = rst_n ? cyc + 1 : 0;
    check("row", row, row_pat(m_row));
    check("key_valid", 4'(key_valid), 4'(m_valid));
    check("key_code", key_code, 4'(m_code));
    check("key_held", 4'(key_held), 4'(m_held));
    check("valid_back_to_back", 4'(prev_valid & key_valid), 4'h0);
    prev_valid = key_valid;
    if (key_valid) vld_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_keys();
    for (int i = 0; i < 4; i++) press_pat[i] = 4'hF;
  endtask

  task automatic run_samples(input int n);
    int s;
    s = 0;
    while (s < n) begin
      tick();
      if (m_smp) s++;
    end
  endtask

  task automatic wait_valid(input int bound, input string name);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check(name, 4'(key_valid), 4'h1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int         r;
    logic [3:0] pat;
    logic [3:0] code;
  } vec_t;
  vec_t vecs [7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_row;
    clear_keys();
    vecs[0] = '{r: 2, pat: 4'b1011, code: 4'hA};
    vecs[1] = '{r: 2, pat: 4'b0101, code: 4'h9};
    vecs[2] = '{r: 0, pat: 4'b1110, code: 4'h0};
    vecs[3] = '{r: 3, pat: 4'b0111, code: 4'hF};
    vecs[4] = '{r: 1, pat: 4'b1100, code: 4'h4};
    vecs[5] = '{r: 3, pat: 4'b1010, code: 4'hC};
    vecs[6] = '{r: 1, pat: 4'b0011, code: 4'h6};

    // Reset state and idle scanning.
    do_reset();
    check("rst_row", row, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", 4'(key_valid), 4'h0);
    check("rst_held", 4'(key_held), 4'h0);
    base = vld_cnt;
    for (int k = 0; k < 32; k++) begin
      exp_row = 4'hF ^ (4'h1 << ((cyc / 4) % 4));
      check("idle_row", row, exp_row);
      tick();
    end
    check_int("idle_no_valid", vld_cnt - base, 0);

    // Press on row 2 column 2, then release with one bounce.
    do_reset();
    press_pat[2] = 4'b1011;
    wait_valid(100, "press_a_valid");
    check_int("press_a_cycle", cyc, 20);
    check("press_a_code", key_code, 4'hA);
    check("press_a_held", 4'(key_held), 4'h1);
    check("press_a_row", row, 4'b1011);
    base = vld_cnt;
    run_samples(2);
    check("press_a_row_frozen", row, 4'b1011);
    press_pat[2] = 4'hF;
    run_samples(1);
    press_pat[2] = 4'b1011;
    run_samples(1);
    press_pat[2] = 4'hF;
    run_samples(2);
    check("bounce_still_held", 4'(key_held), 4'h1);
    run_samples(1);
    check("bounce_released", 4'(key_held), 4'h0);
    check("bounce_row3", row, 4'b0111);
    check("bounce_code_kept", key_code, 4'hA);
    check_int("bounce_no_valid", vld_cnt - base, 0);

    // Short press (2 samples) is rejected and scanning moves on.
    do_reset();
    base = vld_cnt;
    press_pat[0] = 4'b1110;
    run_samples(2);
    check("short_row_frozen", row, 4'b1110);
    press_pat[0] = 4'hF;
    run_samples(1);
    check("short_row_adv", row, 4'b1101);
    check("short_not_held", 4'(key_held), 4'h0);
    check_int("short_no_valid", vld_cnt - base, 0);

    // Reset during debounce and during hold.
    do_reset();
    press_pat[0] = 4'b1110;
    run_samples(2);
    base = vld_cnt;
    rst_n = 1'b0;
    tick();
    press_pat[0] = 4'hF;
    tick();
    rst_n = 1'b1;
    check_int("rst_debounce_no_valid", vld_cnt - base, 0);
    check("rst_debounce_row", row, 4'b1110);
    press_pat[3] = 4'b0111;
    wait_valid(100, "rst_hold_valid");
    run_samples(1);
    rst_n = 1'b0;
    base = vld_cnt;
    tick();
    clear_keys();
    tick();
    rst_n = 1'b1;
    check("rst_hold_held", 4'(key_held), 4'h0);
    check("rst_hold_code", key_code, 4'h0);
    check_int("rst_hold_no_valid", vld_cnt - base, 0);

    // Table of single presses.
    for (int i = 0; i < 7; i++) begin
      clear_keys();
      do_reset();
      press_pat[vecs[i].r] = vecs[i].pat;
      wait_valid(100, "tbl_valid");
      check("tbl_code", key_code, vecs[i].code);
      check("tbl_held", 4'(key_held), 4'h1);
      exp_row = 4'hF ^ (4'h1 << vecs[i].r);
      check("tbl_row_frozen", row, exp_row);
      clear_keys();
      run_samples(3);
      check("tbl_released", 4'(key_held), 4'h0);
      exp_row = 4'hF ^ (4'h1 << ((vecs[i].r + 1) % 4));
      check("tbl_row_next", row, exp_row);
      check("tbl_code_kept", key_code, vecs[i].code);
    end

    // Long hold: auto-repeat when enabled, single pulse otherwise.
    clear_keys();
    do_reset();
    press_pat[1] = 4'b1101;
    wait_valid(100, "repeat_first_valid");
    base = vld_cnt;
    run_samples(11);
    check_int("repeat_pulses", vld_cnt - base, REP_ON ? 2 : 0);
    check("repeat_code", key_code, 4'h5);
    clear_keys();
    run_samples(3);

    // Random presses, bounces, multi-key rows and occasional resets.
    for (int it = 0; it < 150; it++) begin
      clear_keys();
      if ($urandom_range(0, 3) != 0)
        press_pat[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0)
        press_pat[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      run_samples($urandom_range(1, ($urandom_range(0, 4) == 0) ? 14 : 5));
    end
    clear_keys();
    run_samples(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
